alu_muldiv_ctrl: RTL
====================

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >= 8).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  opcode/operands valid this cycle
- opcode  in  6  instruction opcode
- rtype_fncode  in  6  instruction funct field
- op_a  in  WIDTH  rs value
- op_b  in  WIDTH  rt value
- fncode  out  6  ALU function select (combinational)
- stall  out  1  pipeline hold request
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
REQ-003 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 fncode SHALL decode combinationally in every state:
- ADDIU, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW -> 0x21
- ANDI -> 0x24; ORI -> 0x25; XORI -> 0x26
- SLTI -> 0x2A; SLTIU -> 0x2B
- RTYPE (0x00) -> rtype_fncode
- any other opcode -> 0x3F
REQ-005 A muldiv op is valid_in & opcode==0x00 & funct in {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B}.
REQ-006 The FSM SHALL have states IDLE, BUSY, FIXUP; reset state IDLE.
REQ-007 IDLE + muldiv op: capture op_a, op_b and funct at the edge; go to BUSY (or to FIXUP per REQ-018).
REQ-008 BUSY SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; step counter 0..WIDTH-1; go to FIXUP after WIDTH cycles.
REQ-009 FIXUP SHALL apply sign correction; at its closing edge write hi/lo and return to IDLE.
REQ-010 Latency: stall high in issue cycle T and in every BUSY and FIXUP cycle, i.e. WIDTH+2 cycles.
- hi/lo hold new values from cycle T+WIDTH+2.
REQ-011 stall SHALL also assert when valid_in & (MFHI 0x10 | MFLO 0x12 | MTHI 0x11 | MTLO 0x13 | muldiv op) while state != IDLE.
- A stalled muldiv op SHALL NOT be captured until IDLE.
REQ-012 Results:
- MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH product.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of dividend.
REQ-013 Divide by zero: lo = all ones, hi = op_a, in the same latency as a normal divide.
REQ-014 Signed most-negative / -1: lo = most-negative, hi = 0.
REQ-015 MTHI/MTLO in IDLE with valid_in SHALL write op_a to hi/lo at the next edge with no stall.
REQ-016 hi/lo SHALL be unchanged except by REQ-009 and REQ-015.

Reset
REQ-017 When reset is high at an edge, including mid-operation:
- state = IDLE; hi = lo = 0; counter and captured operands cleared.
- stall is low in the following cycle unless REQ-010/REQ-011 conditions hold.

Configuration
REQ-018 Macro MULDIV_FAST_ZERO_EN:
- Defined: a muldiv op with op_a==0 or op_b==0 goes from IDLE directly to FIXUP, so stall is high for 2 cycles; results are still per REQ-012/REQ-013.
- Undefined: all muldiv ops take WIDTH+2 cycles.

Verification (WIDTH=32)
REQ-019 MULTU, op_a=0xFFFFFFFF, op_b=2 -> stall high 34 cycles; then hi=0x00000001, lo=0xFFFFFFFE.
REQ-020 DIV, op_a=-7, op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU, op_a=7, op_b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-021 MFLO presented in cycle 5 of a MULT -> stall stays high until IDLE; then MFLO issues with no stall.
REQ-022 reset pulsed mid-DIV -> next cycle state IDLE, hi=lo=0; a new MULT 3*-4 then gives hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-023 opcode sweep: ORI -> 0x25, SW -> 0x21, SLTIU -> 0x2B, RTYPE funct 0x22 -> 0x22, opcode 0x3F -> 0x3F; results identical in IDLE and in BUSY.
REQ-024 MULDIV_FAST_ZERO_EN defined: MULT, op_a=0, op_b=5 -> stall high 2 cycles, hi=lo=0.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: ALU function decode plus an iterative multiply/divide unit that owns HI/LO.
// Latency: fncode is combinational; a muldiv result lands in hi/lo WIDTH+2 cycles after issue.
// Backpressure: stall is held from issue through BUSY/FIXUP and while any HI/LO/muldiv op waits.
// Optional: MULDIV_FAST_ZERO_EN sends muldiv ops with a zero operand from IDLE straight to FIXUP.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [5:0]       opcode,
  input  logic [5:0]       rtype_fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [5:0]       fncode,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LWL   = 6'h22;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWR   = 6'h26;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;        // captured raw operands
  logic             div_q, sgn_q;    // captured op kind: divide / signed
  logic [WIDTH-1:0] acc_hi, acc_lo;  // product halves, or remainder / quotient-dividend

  logic             is_rtype, muldiv_op, mthi_op, mtlo_op;
  logic             in_neg_a;
  logic [WIDTH-1:0] in_mag_a;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

  assign is_rtype  = (opcode == OP_RTYPE);
  // funct 0x18..0x1B share the upper bits 0110
  assign muldiv_op = valid_in & is_rtype & (rtype_fncode[5:2] == 4'b0110);
  assign mthi_op   = valid_in & is_rtype & (rtype_fncode == FN_MTHI);
  assign mtlo_op   = valid_in & is_rtype & (rtype_fncode == FN_MTLO);

  // Outside IDLE every cycle stalls, which already covers HI/LO and muldiv ops waiting for IDLE.
  assign stall = (state != IDLE) | muldiv_op;

  // Dividend/multiplier magnitude is taken straight from the inputs at capture time.
  assign in_neg_a = ~rtype_fncode[0] & op_a[WIDTH-1];
  assign in_mag_a = in_neg_a ? -op_a : op_a;

  assign neg_a = sgn_q & a_q[WIDTH-1];
  assign neg_b = sgn_q & b_q[WIDTH-1];
  assign mag_b = neg_b ? -b_q : b_q;

  // ALU function select, decoded in every state
  always_comb begin
    fncode = 6'h3F;
    case (opcode)
      OP_ADDIU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
      OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW: fncode = 6'h21;
      OP_ANDI:  fncode = 6'h24;
      OP_ORI:   fncode = 6'h25;
      OP_XORI:  fncode = 6'h26;
      OP_SLTI:  fncode = 6'h2A;
      OP_SLTIU: fncode = 6'h2B;
      OP_RTYPE: fncode = rtype_fncode;
      default:  fncode = 6'h3F;
    endcase
  end

  // One iteration: shift-add multiply (right shift) or restoring divide (left shift)
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mag_b};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction and special cases applied in FIXUP.
  // Most-negative / -1 needs no override: the magnitude quotient 2^(WIDTH-1) already reads back
  // as the most-negative value and the remainder is zero.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    rem_fix  = neg_a ? -acc_hi : acc_hi;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end else if ((a_q == '0) || (b_q == '0)) begin
      // a skipped iteration leaves the accumulators partial; a zero operand always yields zero
      res_hi = '0;
      res_lo = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (muldiv_op) begin
`ifdef MULDIV_FAST_ZERO_EN
          state_nxt = ((op_a == '0) || (op_b == '0)) ? FIXUP : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY:    if (cnt == LAST) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      sgn_q  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (muldiv_op) begin
            a_q    <= op_a;
            b_q    <= op_b;
            div_q  <= rtype_fncode[1];
            sgn_q  <= ~rtype_fncode[0];
            acc_hi <= '0;
            acc_lo <= in_mag_a;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: written only by FIXUP completion or by MTHI/MTLO in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE) begin
      if (mthi_op) hi <= op_a;
      if (mtlo_op) lo <= op_a;
    end
  end

endmodule
